// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register slave.
// Holds the FSM state encoding and the bus bit levels.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_ADDR,
    ST_REG_ADDR,
    ST_ACK_REG,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_RD_ACK
  } state_e;

  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_slave_regs_if.sv
// Register-side bus between the I2C slave and the register file it serves.
interface i2c_slave_regs_if;

  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_data;
  logic       busy;

  modport slave (
    output reg_addr, reg_wr_en, reg_wr_data, busy,
    input  reg_rd_data
  );

  modport master (
    input  reg_addr, reg_wr_en, reg_wr_data, busy,
    output reg_rd_data
  );

endinterface

// File: rtl/i2c_slave_sync.sv
// SCL/SDA synchronizers (SYNC_STAGES >= 2) with edge, START and STOP detection
// on the synchronized levels.
module i2c_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // NOTE: chains reset to 1 (idle bus level) so reset release never fakes an edge or START.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing an 8-bit register pointer with byte write strobes and reads.
// Define I2C_SLAVE_AUTOINC_EN to auto-increment the pointer on bursts.
module i2c_slave_regs
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                i2c_sclk,
  inout  wire                 i2c_sdat,
  i2c_slave_regs_if.slave     rbus
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .scl_in    (i2c_sclk),
    .sda_in    (i2c_sdat),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic       reg_wr_en_q, reg_wr_en_d;
  logic [7:0] reg_wr_data_q, reg_wr_data_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       master_ack_q, master_ack_d;

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    sda_low_d     = sda_low_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_data_d = reg_wr_data_q;
    busy_d        = busy_q;
    rw_d          = rw_q;
    master_ack_d  = master_ack_q;
`ifdef I2C_SLAVE_AUTOINC_EN
    if (reg_wr_en_q) reg_addr_d = reg_addr_q + 8'd1;
`endif

    if (start_det) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = '0;
      rx_d      = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (scl_rise && bit_cnt_q != BITS_PER_BYTE) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
            bit_cnt_d = '0;
            sda_low_d = 1'b1;
            case (state_q)
              ST_DEV_ADDR: begin
                // General call (0x00) is never acknowledged.
                if (rx_q[7:1] == DEV_ADDR && rx_q[7:1] != 7'd0) begin
                  state_d = ST_ACK_ADDR;
                  rw_d    = rx_q[0];
                end else begin
                  state_d   = ST_IDLE;
                  sda_low_d = 1'b0;
                  busy_d    = 1'b0;
                end
              end
              ST_REG_ADDR: begin
                reg_addr_d = rx_q;
                state_d    = ST_ACK_REG;
              end
              default: begin
                reg_wr_en_d   = 1'b1;
                reg_wr_data_d = rx_q;
                state_d       = ST_ACK_WR;
              end
            endcase
          end
        end
        ST_ACK_ADDR: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q == I2C_WR) begin
              sda_low_d = 1'b0;
              rx_d      = '0;
              state_d   = ST_REG_ADDR;
            end else begin
              tx_d      = rbus.reg_rd_data;
              sda_low_d = ~rbus.reg_rd_data[7];
              state_d   = ST_RD_DATA;
            end
          end
        end
        ST_ACK_REG, ST_ACK_WR: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            rx_d      = '0;
            sda_low_d = 1'b0;
            state_d   = ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            state_d   = ST_RD_ACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            tx_d      = {tx_q[6:0], tx_q[7]};
            sda_low_d = ~tx_q[6];
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            master_ack_d = sda_s;
`ifdef I2C_SLAVE_AUTOINC_EN
            if (sda_s == I2C_ACK) reg_addr_d = reg_addr_q + 8'd1;
`endif
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (master_ack_q == I2C_NACK) begin
              sda_low_d = 1'b0;
              state_d   = ST_IDLE;
            end else begin
              tx_d      = rbus.reg_rd_data;
              sda_low_d = ~rbus.reg_rd_data[7];
              state_d   = ST_RD_DATA;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      sda_low_q     <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_data_q <= '0;
      busy_q        <= 1'b0;
      rw_q          <= 1'b0;
      master_ack_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      sda_low_q     <= sda_low_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_data_q <= reg_wr_data_d;
      busy_q        <= busy_d;
      rw_q          <= rw_d;
      master_ack_q  <= master_ack_d;
    end
  end

  // Open drain: only ever pull low, and the async reset releases the line at once.
  assign i2c_sdat         = sda_low_q ? 1'b0 : 1'bz;
  assign rbus.reg_addr    = reg_addr_q;
  assign rbus.reg_wr_en   = reg_wr_en_q;
  assign rbus.reg_wr_data = reg_wr_data_q;
  assign rbus.busy        = busy_q;

endmodule
